// File: rtl/stereo_pkg.sv
// Shared stereo-datapath definitions.
// Holds the default geometry of the census / Hamming-cost path, the
// scheduler state encoding, the in-flight tag layout and a small cost
// comparison helper. Modules import this package and may override the
// geometry through their own parameters (kept consistent with these
// defaults because tag_t is sized from them).
package stereo_pkg;

    localparam int DEF_CENSUS_BITS = 20;  // census word width
    localparam int DEF_CNT_W       = 5;   // cost width, holds 0..DEF_CENSUS_BITS
    localparam int DEF_NUM_DISP    = 16;  // disparity candidates per pixel
    localparam int DEF_DISP_W      = 4;   // clog2(DEF_NUM_DISP)
    localparam int DEF_PIPE_LAT    = 5;   // treesum latency in cycles

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Travels alongside each word through the cost pipeline; valid=0 marks a bubble.
    typedef struct packed {
        logic                  valid;
        logic [DEF_DISP_W-1:0] idx;
    } tag_t;

    // Strictly-lower cost wins, so on ties the earlier (lower) disparity is kept.
    function automatic logic cost_better(input logic [DEF_CNT_W-1:0] cand,
                                         input logic [DEF_CNT_W-1:0] best);
        return (cand < best);
    endfunction

endpackage

// File: rtl/treesum.sv
// Pipelined Hamming-weight (popcount) engine.
// bitsin presented in cycle t produces its set-bit count on cntout in cycle
// t+5: input register, four quarter counts, two half sums, total, output
// register. The pipeline carries no valid; callers tag their own words.
// CENSUS_BITS must be a multiple of 4.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high, clears every pipeline stage
//   bitsin - word to count
//   cntout - number of ones in the word issued PIPE_LAT cycles earlier
module treesum
    import stereo_pkg::*;
#(
    parameter int CENSUS_BITS = DEF_CENSUS_BITS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CENSUS_BITS-1:0] bitsin,
    output logic [CNT_W-1:0]       cntout
);

    localparam int QW = CENSUS_BITS / 4;

    logic [CENSUS_BITS-1:0] bits_r;
    logic [CNT_W-1:0]       quarter_s [4];
    logic [CNT_W-1:0]       quarter_r [4];
    logic [CNT_W-1:0]       half_r    [2];
    logic [CNT_W-1:0]       total_r;
    logic [CNT_W-1:0]       cntout_r;

    // Count the ones in each quarter of the registered input word.
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            quarter_s[q] = {CNT_W{1'b0}};
            for (int b = 0; b < QW; b++) begin
                quarter_s[q] = quarter_s[q] + CNT_W'(bits_r[q*QW + b]);
            end
        end
    end

    // Adder-tree pipeline stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits_r   <= {CENSUS_BITS{1'b0}};
            for (int q = 0; q < 4; q++) quarter_r[q] <= {CNT_W{1'b0}};
            half_r[0] <= {CNT_W{1'b0}};
            half_r[1] <= {CNT_W{1'b0}};
            total_r  <= {CNT_W{1'b0}};
            cntout_r <= {CNT_W{1'b0}};
        end else begin
            bits_r    <= bitsin;
            for (int q = 0; q < 4; q++) quarter_r[q] <= quarter_s[q];
            half_r[0] <= quarter_r[0] + quarter_r[1];
            half_r[1] <= quarter_r[2] + quarter_r[3];
            total_r   <= half_r[0] + half_r[1];
            cntout_r  <= total_r;
        end
    end

    assign cntout = cntout_r;

endmodule

// File: rtl/disparity_wta_scheduler.sv
// Winner-take-all disparity scheduler.
// Accepts one pixel (left census word plus NUM_DISP right candidates),
// streams left^right[d] through a single shared treesum one candidate per
// cycle, follows each word with a tag shift register of the same depth and
// keeps the minimum-cost disparity. The result is held until accepted.
// Ports:
//   clk, reset      - clock; asynchronous active-high reset (also clears treesum)
//   in_valid/ready  - pixel handshake; ready only while idle
//   left_census     - left-image census word
//   right_census    - candidates, slice d = [d*CENSUS_BITS +: CENSUS_BITS]
//   out_valid/ready - result handshake; valid held until accepted
//   out_disp        - winning disparity (lowest index on ties)
//   out_cost        - Hamming cost of the winner
module disparity_wta_scheduler
    import stereo_pkg::*;
#(
    parameter int CENSUS_BITS = DEF_CENSUS_BITS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int NUM_DISP    = DEF_NUM_DISP,
    parameter int DISP_W      = DEF_DISP_W,
    parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CENSUS_BITS-1:0]          left_census,
    input  logic [NUM_DISP*CENSUS_BITS-1:0] right_census,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DISP_W-1:0]               out_disp,
    output logic [CNT_W-1:0]                out_cost
);

    localparam logic [DISP_W-1:0] LAST_IDX  = DISP_W'(NUM_DISP - 1);
    localparam logic [DISP_W-1:0] FIRST_IDX = DISP_W'(0);

    state_e                 state_r;
    state_e                 state_n;
    logic [DISP_W-1:0]      idx_r;
    logic [CENSUS_BITS-1:0] left_r;
    logic [CENSUS_BITS-1:0] right_r [NUM_DISP];
    tag_t                   tag_r   [PIPE_LAT];
    tag_t                   push_tag_s;
    tag_t                   tail_s;
    logic [CENSUS_BITS-1:0] bitsin_s;
    logic [CNT_W-1:0]       cntout_s;
    logic                   accept_s;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [DISP_W-1:0]      best_disp_r;
    logic [CNT_W-1:0]       best_cost_r;

    assign tail_s   = tag_r[PIPE_LAT-1];
    assign accept_s = in_valid && (state_r == IDLE);

    // Shared cost engine; its reset is tied to ours so an abandoned pixel leaves nothing behind.
    treesum #(
        .CENSUS_BITS (CENSUS_BITS),
        .CNT_W       (CNT_W)
    ) u_treesum (
        .clk    (clk),
        .reset  (reset),
        .bitsin (bitsin_s),
        .cntout (cntout_s)
    );

    // Next-state, issue data and tag to push this cycle.
    always_comb begin
        state_n    = state_r;
        bitsin_s   = {CENSUS_BITS{1'b0}};
        push_tag_s = '{valid: 1'b0, idx: FIRST_IDX};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                bitsin_s   = left_r ^ right_r[idx_r];
                push_tag_s = '{valid: 1'b1, idx: idx_r};
                if (idx_r == LAST_IDX) begin
                    state_n = DRAIN;
                end else begin
                    state_n = ISSUE;
                end
            end
            DRAIN: begin
                // The last candidate's cost is captured at the end of this cycle.
                if (tail_s.valid && (tail_s.idx == LAST_IDX)) begin
                    state_n = DONE;
                end else begin
                    state_n = DRAIN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, issue counter, handshake flags and latched census words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= FIRST_IDX;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            left_r      <= {CENSUS_BITS{1'b0}};
            for (int d = 0; d < NUM_DISP; d++) right_r[d] <= {CENSUS_BITS{1'b0}};
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
            if (accept_s) begin
                idx_r  <= FIRST_IDX;
                left_r <= left_census;
                for (int d = 0; d < NUM_DISP; d++) begin
                    right_r[d] <= right_census[d*CENSUS_BITS +: CENSUS_BITS];
                end
            end else if (state_r == ISSUE) begin
                idx_r <= idx_r + DISP_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Tag shift register, same depth as the treesum pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_LAT; k++) tag_r[k] <= '{valid: 1'b0, idx: FIRST_IDX};
        end else begin
            tag_r[0] <= push_tag_s;
            for (int k = 1; k < PIPE_LAT; k++) tag_r[k] <= tag_r[k-1];
        end
    end

    // Winner-take-all capture: candidate 0 seeds the best, later ones must be strictly cheaper.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_disp_r <= FIRST_IDX;
            best_cost_r <= {CNT_W{1'b0}};
        end else if (tail_s.valid &&
                     ((tail_s.idx == FIRST_IDX) || cost_better(cntout_s, best_cost_r))) begin
            best_disp_r <= tail_s.idx;
            best_cost_r <= cntout_s;
        end else begin
            best_disp_r <= best_disp_r;
            best_cost_r <= best_cost_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_disp  = best_disp_r;
    assign out_cost  = best_cost_r;

endmodule
